// File: rtl/alu_reg_seq_if.sv
// Operand/result bundle between the board switch/key logic and alu_reg_seq.
// Handshake: Go is a request that is accepted on any posedge where Busy=0; Done pulses for one cycle when ALUout carries the new result.
interface alu_reg_seq_if #(
    parameter int WIDTH = 4
);
    localparam int OUT_W = 2 * WIDTH;

    logic             Go;
    logic [WIDTH-1:0] Data;
    logic [2:0]       Function;
    logic [OUT_W-1:0] ALUout;
    logic             Busy;
    logic             Done;
    logic             Zero;

    modport master (output Go, Data, Function, input ALUout, Busy, Done, Zero);
    modport slave  (input Go, Data, Function, output ALUout, Busy, Done, Zero);
endinterface

// File: rtl/alu_reg_seq.sv
// Registered WIDTH-bit ALU with 2*WIDTH accumulator and an iterative shift-add multiplier.
// Optional macro ALU_ZERO_FLAG_EN adds a registered ALUout==0 flag on Zero.
module alu_reg_seq #(
    parameter int WIDTH = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    alu_reg_seq_if.slave bus,
    output logic [0:0]   dbg_state
);
    localparam int OUT_W = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [OUT_W-1:0] alu_out_q, alu_out_d;
    logic             done_q, done_d;
    logic [OUT_W-1:0] mcand_q, mcand_d;
    logic [OUT_W-1:0] prod_q, prod_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] b_op;
    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;
    logic [OUT_W-1:0] op_result;
    logic [OUT_W-1:0] step_sum;

    always_comb begin
        b_op      = alu_out_q[WIDTH-1:0];
        a_ext     = OUT_W'(bus.Data);
        b_ext     = OUT_W'(b_op);
        op_result = alu_out_q;
        case (bus.Function)
            3'b000:  op_result = a_ext + b_ext;
            3'b001:  op_result = a_ext - b_ext;
            3'b010:  op_result = {{WIDTH{b_op[WIDTH-1]}}, b_op};
            3'b011:  op_result = OUT_W'(|{bus.Data, b_op});
            3'b100:  op_result = OUT_W'(&{bus.Data, b_op});
            3'b101:  op_result = (int'(b_op) >= OUT_W) ? '0 : (a_ext << b_op);
            default: op_result = alu_out_q;
        endcase
    end

    // Multiplicand walks left while the multiplier drains right; LSB selects the add.
    assign step_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        done_d    = 1'b0;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Go) begin
                    if (bus.Function == 3'b110) begin
                        mcand_d  = a_ext;
                        mplier_d = b_op;
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        alu_out_d = op_result;
                        done_d    = 1'b1;
                    end
                end
            end
            S_MUL: begin
                prod_d   = step_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    alu_out_d = step_sum;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            alu_out_q <= '0;
            done_q    <= 1'b0;
            mcand_q   <= '0;
            prod_q    <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            done_q    <= done_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    logic zero_q, zero_d;

    assign zero_d = (alu_out_d == '0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign bus.Zero = zero_q;
`else
    assign bus.Zero = 1'b0;
`endif

    assign bus.ALUout = alu_out_q;
    assign bus.Busy   = (state_q == S_MUL);
    assign bus.Done   = done_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_alu_reg_seq.sv
// Directed bench for alu_reg_seq (WIDTH=4): arithmetic reference model checked every cycle,
// plus hand-computed accumulator values along the stimulus sequence.
module tb_alu_reg_seq;
    localparam int WIDTH = 4;
    localparam int OUT_W = 2 * WIDTH;
    localparam int FULL  = 1 << OUT_W;
    localparam int HALF  = 1 << (WIDTH - 1);
`ifdef ALU_ZERO_FLAG_EN
    localparam logic ZERO_EN = 1'b1;
`else
    localparam logic ZERO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [0:0] dbg_state;
    logic       check_en;
    int         checks;
    int         errors;

    alu_reg_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_reg_seq #(.WIDTH(WIDTH)) dut (
        .Clock     (clk),
        .Reset     (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: plain integer arithmetic on the opcode definitions
    function automatic logic [OUT_W-1:0] model_op(input int fn, input int a, input int b,
                                                  input logic [OUT_W-1:0] cur);
        int r;
        case (fn)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = (b >= HALF) ? (b + FULL - (1 << WIDTH)) : b;
            3:       r = (a != 0 || b != 0) ? 1 : 0;
            4:       r = (a == (1 << WIDTH) - 1 && b == (1 << WIDTH) - 1) ? 1 : 0;
            5:       r = (b >= OUT_W) ? 0 : a * (1 << b);
            default: r = int'(cur);
        endcase
        return OUT_W'(r & (FULL - 1));
    endfunction

    logic [OUT_W-1:0] m_out;
    logic [OUT_W-1:0] m_prod;
    logic             m_busy;
    logic             m_done;
    int               m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_out  <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else if (m_busy) begin
            m_done <= 1'b0;
            if (m_left == 1) begin
                m_out  <= m_prod;
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
            m_left <= m_left - 1;
        end else if (bus.Go) begin
            if (bus.Function == 3'b110) begin
                m_prod <= OUT_W'(int'(bus.Data) * int'(m_out[WIDTH-1:0]));
                m_busy <= 1'b1;
                m_left <= WIDTH;
                m_done <= 1'b0;
            end else begin
                m_out  <= model_op(int'(bus.Function), int'(bus.Data), int'(m_out[WIDTH-1:0]), m_out);
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    // scoreboard: every cycle once out of the first reset
    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_aluout", bus.ALUout, m_out);
            chk("cyc_busy", bus.Busy, m_busy);
            chk("cyc_done", bus.Done, m_done);
            chk("cyc_zero", bus.Zero, ZERO_EN & (m_out == '0));
        end
    end

    // driver: call at a negedge; leaves Go low at the negedge after the accept edge
    task automatic op(input logic [2:0] fn, input logic [WIDTH-1:0] d);
        bus.Go       = 1'b1;
        bus.Function = fn;
        bus.Data     = d;
        @(negedge clk);
        bus.Go = 1'b0;
    endtask

    task automatic lit(input string name, input logic [OUT_W-1:0] exp_out);
        chk(name, bus.ALUout, exp_out);
    endtask

    int n;

    initial begin
        checks       = 0;
        errors       = 0;
        check_en     = 1'b0;
        rst          = 1'b1;
        bus.Go       = 1'b0;
        bus.Function = 3'b000;
        bus.Data     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        check_en = 1'b1;
        lit("reset_aluout", 8'h00);
        chk("reset_busy", bus.Busy, 1'b0);
        chk("reset_done", bus.Done, 1'b0);
        chk("reset_zero", bus.Zero, ZERO_EN);

        op(3'b000, 4'h5);  lit("add_5", 8'h05);
        chk("add_5_done", bus.Done, 1'b1);
        @(negedge clk);
        chk("done_one_cycle", bus.Done, 1'b0);
        op(3'b000, 4'hF);  lit("add_carry", 8'h14);
        op(3'b001, 4'h9);  lit("sub_pos", 8'h05);
        op(3'b001, 4'h2);  lit("sub_wrap", 8'hFD);
        op(3'b010, 4'h0);  lit("sext_neg", 8'hFD);
        op(3'b011, 4'h0);  lit("or_b", 8'h01);
        op(3'b000, 4'h3);  lit("add_to_4", 8'h04);

        // multiply 0xB * 4 with a Go injected mid-flight that must be ignored
        op(3'b110, 4'hB);
        n = 0;
        while (bus.Busy && n < 20) begin
            lit("mul_hold", 8'h04);
            if (n == 1) begin
                bus.Go       = 1'b1;
                bus.Function = 3'b000;
                bus.Data     = 4'h3;
            end
            if (n == 2) bus.Go = 1'b0;
            n++;
            @(negedge clk);
        end
        bus.Go = 1'b0;
        chk("mul_busy_cycles", n, 4);
        lit("mul_result", 8'h2C);
        chk("mul_done", bus.Done, 1'b1);

        op(3'b100, 4'h0);  lit("and_zero", 8'h00);
        chk("zero_flag", bus.Zero, ZERO_EN);
        op(3'b000, 4'h9);  lit("add_9", 8'h09);
        op(3'b101, 4'h3);  lit("shl_overflow", 8'h00);
        op(3'b000, 4'h2);  lit("add_2", 8'h02);
        op(3'b101, 4'h3);  lit("shl_3_by_2", 8'h0C);
        op(3'b000, 4'h3);  lit("add_to_f", 8'h0F);
        op(3'b100, 4'hF);  lit("and_all_ones", 8'h01);

        // reset aborts a multiply one cycle in
        op(3'b110, 4'h5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lit("abort_aluout", 8'h00);
        chk("abort_busy", bus.Busy, 1'b0);
        chk("abort_done", bus.Done, 1'b0);
        repeat (5) @(negedge clk);
        op(3'b000, 4'h7);  lit("after_abort", 8'h07);

        // Go held high: one add per edge
        bus.Go       = 1'b1;
        bus.Function = 3'b000;
        bus.Data     = 4'h1;
        repeat (3) @(negedge clk);
        bus.Go = 1'b0;
        lit("back_to_back", 8'h0A);
        chk("back_to_back_done", bus.Done, 1'b1);
        op(3'b111, 4'h4);  lit("hold", 8'h0A);

        // 0xF * 0xA = 150
        op(3'b110, 4'hF);
        n = 0;
        while (bus.Busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("mul2_busy_cycles", n, 4);
        lit("mul2_result", 8'h96);

        repeat (2) @(negedge clk);
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
